// File: rtl/reg_file.sv
// Combined vector/scalar register file for the SIMD datapath.
// Two combinational read ports, one synchronous write port; scalar reads broadcast to all lanes.
module reg_file #(
    parameter int registerSize     = 16,
    parameter int registerQuantity = 4,
    parameter int selectionBits    = 4,
    parameter int vectorSize       = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               regWrEnSc,
    input  logic                               regWrEnVec,
    input  logic [selectionBits-1:0]           rSel1,
    input  logic [selectionBits-1:0]           rSel2,
    input  logic [selectionBits-1:0]           regToWrite,
    input  logic [vectorSize*registerSize-1:0] dataIn,
    output logic [vectorSize*registerSize-1:0] operand1,
    output logic [vectorSize*registerSize-1:0] operand2
);

    localparam int totalRegs     = 2 ** selectionBits;
    localparam int scalarCount   = totalRegs - registerQuantity;
    localparam int vecIdxBits    = (registerQuantity > 1) ? $clog2(registerQuantity) : 1;
    localparam int scalarIdxBits = (scalarCount > 1) ? $clog2(scalarCount) : 1;
    localparam int vecWidth      = vectorSize * registerSize;

    localparam logic [selectionBits-1:0] vecLimit = selectionBits'(registerQuantity);

    logic [vecWidth-1:0]     vecRegs    [registerQuantity];
    logic [registerSize-1:0] scalarRegs [scalarCount];

    logic [selectionBits-1:0] wrScalarOffset;
    logic                     wrIsVector;

    assign wrIsVector     = (regToWrite < vecLimit);
    assign wrScalarOffset = regToWrite - vecLimit;

    // Scalar storage is indexed relative to the first scalar slot.
    function automatic logic [vecWidth-1:0] readReg(input logic [selectionBits-1:0] sel);
        logic [selectionBits-1:0] offset;
        offset = sel - vecLimit;
        if (sel < vecLimit)
            readReg = vecRegs[sel[vecIdxBits-1:0]];
        else
            readReg = {vectorSize{scalarRegs[offset[scalarIdxBits-1:0]]}};
    endfunction

    always_comb begin
        operand1 = readReg(rSel1);
        operand2 = readReg(rSel2);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < registerQuantity; i++)
                vecRegs[i] <= '0;
            for (int i = 0; i < scalarCount; i++)
                scalarRegs[i] <= '0;
        end else begin
            if (regWrEnVec && wrIsVector)
                vecRegs[regToWrite[vecIdxBits-1:0]] <= dataIn;
            if (regWrEnSc && !wrIsVector)
                scalarRegs[wrScalarOffset[scalarIdxBits-1:0]] <= dataIn[registerSize-1:0];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected read data, a negedge monitor compares.
module tb_reg_file;

    logic        clk;
    logic        reset;
    logic        regWrEnSc;
    logic        regWrEnVec;
    logic [3:0]  rSel1;
    logic [3:0]  rSel2;
    logic [3:0]  regToWrite;
    logic [63:0] dataIn;
    logic [63:0] operand1;
    logic [63:0] operand2;

    typedef struct {
        string       name;
        logic [63:0] e1;
        logic [63:0] e2;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stimDone = 0;

    reg_file #(
        .registerSize(16),
        .registerQuantity(4),
        .selectionBits(4),
        .vectorSize(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .regWrEnSc(regWrEnSc),
        .regWrEnVec(regWrEnVec),
        .rSel1(rSel1),
        .rSel2(rSel2),
        .regToWrite(regToWrite),
        .dataIn(dataIn),
        .operand1(operand1),
        .operand2(operand2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs; the expectation is for the reads before the coming edge.
    task automatic step(input bit doCheck, input logic rst, input logic sc, input logic vec,
                        input logic [3:0] wr, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [63:0] d, input logic [63:0] e1, input logic [63:0] e2,
                        input string nm);
        exp_t e;
        reset      = rst;
        regWrEnSc  = sc;
        regWrEnVec = vec;
        regToWrite = wr;
        rSel1      = s1;
        rSel2      = s2;
        dataIn     = d;
        if (doCheck) begin
            e.name = nm;
            e.e1   = e1;
            e.e2   = e2;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                checks++;
                if (operand1 !== e.e1 || operand2 !== e.e2) begin
                    failures++;
                    $display("FAIL %s: operand1=%h operand2=%h required operand1=%h operand2=%h",
                             e.name, operand1, operand2, e.e1, e.e2);
                end
            end
        end
    end

    localparam logic [63:0] S4  = 64'h0004_0004_0004_0004;
    localparam logic [63:0] S7  = 64'h0007_0007_0007_0007;
    localparam logic [63:0] S9  = 64'h0009_0009_0009_0009;
    localparam logic [63:0] S42 = 64'h0042_0042_0042_0042;
    localparam logic [63:0] VDB = 64'h0000_0000_DEAD_BEEF;
    localparam logic [63:0] VCF = 64'hCAFE_F00D_0123_4567;

    initial begin : stimulus
        reset = 1'b0; regWrEnSc = 1'b0; regWrEnVec = 1'b0;
        regToWrite = '0; rSel1 = '0; rSel2 = '0; dataIn = '0;

        //    chk rst sc vec wr     s1     s2     dataIn                  e1   e2
        step(0, 0, 0, 0, 4'd0,  4'd0,  4'd0,  64'h0,                  0,   0,   "init_reset");
        step(1, 1, 0, 0, 4'd0,  4'd12, 4'd0,  64'h0,                  0,   0,   "reset_idx12_idx0");
        step(1, 1, 1, 0, 4'd4,  4'd4,  4'd1,  64'h4,                  0,   0,   "sc_write_same_cycle");
        step(1, 1, 0, 0, 4'd0,  4'd4,  4'd1,  64'h0,                  S4,  0,   "sc_read_idx4");
        step(1, 1, 0, 0, 4'd0,  4'd0,  4'd7,  64'h0,                  0,   0,   "v0_untouched");
        step(1, 1, 0, 1, 4'd3,  4'd3,  4'd1,  64'hDEAD_BEEF,          0,   0,   "vec_write_same_cycle");
        step(1, 1, 0, 0, 4'd0,  4'd3,  4'd1,  64'h0,                  VDB, 0,   "vec_read_v3");
        step(1, 1, 0, 0, 4'd0,  4'd7,  4'd3,  64'h0,                  0,   VDB, "idx7_untouched");
        step(1, 1, 0, 0, 4'd0,  4'd4,  4'd3,  64'h0,                  S4,  VDB, "dual_read");
        step(1, 1, 1, 0, 4'd13, 4'd13, 4'd12, 64'h7,                  0,   0,   "special13_same_cycle");
        step(1, 1, 1, 0, 4'd14, 4'd13, 4'd14, 64'h1111_2222_3333_0009, S7, 0,   "special13_read");
        step(1, 1, 0, 0, 4'd0,  4'd14, 4'd13, 64'h0,                  S9,  S7,  "special14_lane0_only");
        step(1, 1, 1, 0, 4'd2,  4'd2,  4'd2,  64'hAAAA_AAAA_AAAA_5555, 0,   0,   "sc_en_vec_idx");
        step(1, 1, 0, 1, 4'd5,  4'd2,  4'd5,  64'h1234_5678_9ABC_DEF0, 0,   0,   "v2_after_sc_en");
        step(1, 1, 0, 0, 4'd0,  4'd2,  4'd5,  64'h0,                  0,   0,   "idx5_after_vec_en");
        step(1, 1, 1, 1, 4'd1,  4'd1,  4'd1,  VCF,                    0,   0,   "both_en_vec_idx");
        step(1, 1, 1, 1, 4'd6,  4'd1,  4'd6,  64'h5A5A_5A5A_5A5A_0042, VCF, 0,   "both_en_v1_written");
        step(1, 1, 0, 0, 4'd0,  4'd6,  4'd4,  64'h0,                  S42, S4,  "both_en_sc_idx");
        step(1, 0, 0, 1, 4'd0,  4'd3,  4'd14, 64'hFFFF_FFFF_FFFF_FFFF, VDB, S9,  "pre_midrun_reset");
        for (int i = 0; i < 16; i++)
            step(1, 1, 0, 0, 4'd0, 4'(i), 4'(15 - i), 64'h0, 0, 0, $sformatf("post_reset_idx%0d", i));

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d required=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
